// File: rtl/dma_fifo_pkg.sv
// Shared types, constants and elaboration helpers for the MM2S stream FIFO.
package dma_fifo_pkg;

  localparam int unsigned KEEP_BITS_PER_BYTE = 8;

  typedef enum logic {
    FIFO_CUT_THROUGH = 1'b0,
    FIFO_STORE_FWD   = 1'b1
  } fifo_mode_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dma_fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module dma_fifo_mem
  import dma_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dma_stream_fifo.sv
// First-word-fall-through stream FIFO carrying {last, keep, data} beats with
// cut-through or store-and-forward release. Optional stats via DMA_STREAM_FIFO_STATS_EN.
module dma_stream_fifo
  import dma_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 1,
  parameter int unsigned PKT_MODE  = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [DATA_W-1:0]                   s_data,
  input  logic [DATA_W/KEEP_BITS_PER_BYTE-1:0] s_keep,
  input  logic                                s_last,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DATA_W-1:0]                   m_data,
  output logic [DATA_W/KEEP_BITS_PER_BYTE-1:0] m_keep,
  output logic                                m_last,
  output logic                                full,
  output logic                                empty,
  output logic                                almost_full,
  output logic                                almost_empty,
  output logic [lvl_w(DEPTH)-1:0]             level,
  output logic [lvl_w(DEPTH)-1:0]             pkt_count
`ifdef DMA_STREAM_FIFO_STATS_EN
  ,
  output logic [lvl_w(DEPTH)-1:0]             hwm,
  output logic                                ovf_sticky
`endif
);

  localparam int unsigned KEEP_W = DATA_W / KEEP_BITS_PER_BYTE;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = lvl_w(DEPTH);
  localparam int unsigned ENT_W  = DATA_W + KEEP_W + 1;
  localparam fifo_mode_e  MODE   = (PKT_MODE != 0) ? FIFO_STORE_FWD : FIFO_CUT_THROUGH;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Parameter sanity checks
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_err_depth
    $error("dma_stream_fifo: DEPTH=%0d must be a power of two >= 2", DEPTH);
  end
  if ((DATA_W % KEEP_BITS_PER_BYTE) != 0 || DATA_W == 0) begin : g_err_width
    $error("dma_stream_fifo: DATA_W=%0d must be a nonzero multiple of 8", DATA_W);
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_err_af
    $error("dma_stream_fifo: AF_THRESH=%0d out of range 1..%0d", AF_THRESH, DEPTH);
  end
  if (AE_THRESH > DEPTH - 1) begin : g_err_ae
    $error("dma_stream_fifo: AE_THRESH=%0d out of range 0..%0d", AE_THRESH, DEPTH - 1);
  end
  if (PKT_MODE > 1) begin : g_err_mode
    $error("dma_stream_fifo: PKT_MODE=%0d must be 0 or 1", PKT_MODE);
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] pkt_count_q, pkt_count_d;

  logic   push;
  logic   pop;
  entry_t wr_entry;
  entry_t rd_entry;

  dma_fifo_mem #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Status flags straight off the registered occupancy
  assign full         = (level_q == LVL_W'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LVL_W'(AF_THRESH));
  assign almost_empty = (level_q <= LVL_W'(AE_THRESH));
  assign level        = level_q;
  assign pkt_count    = pkt_count_q;

  // Full is not pass-through: a same-cycle pop never opens the input
  assign s_ready = !full && !flush;
  assign push    = s_valid && s_ready;

  // Store-and-forward holds the head until a whole packet is stored; a full
  // FIFO with no complete packet releases anyway so oversize packets drain.
  always_comb begin
    m_valid = !empty && !flush;
    if (MODE == FIFO_STORE_FWD) begin
      m_valid = m_valid && ((pkt_count_q != '0) || full);
    end
  end

  assign pop = m_valid && m_ready;

  always_comb begin
    wr_entry      = '0;
    wr_entry.last = s_last;
    wr_entry.keep = s_keep;
    wr_entry.data = s_data;
  end

  assign m_data = rd_entry.data;
  assign m_keep = rd_entry.keep;
  assign m_last = rd_entry.last;

  // Next-state for pointers and counters
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pkt_count_d = pkt_count_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      pkt_count_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      case ({push && s_last, pop && rd_entry.last})
        2'b10:   pkt_count_d = pkt_count_q + LVL_W'(1);
        2'b01:   pkt_count_d = pkt_count_q - LVL_W'(1);
        default: pkt_count_d = pkt_count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
    end
  end

`ifdef DMA_STREAM_FIFO_STATS_EN
  logic [LVL_W-1:0] hwm_q, hwm_d;
  logic             ovf_sticky_q, ovf_sticky_d;

  // High-water mark tracks the post-edge level so it never lags occupancy
  always_comb begin
    hwm_d        = hwm_q;
    ovf_sticky_d = ovf_sticky_q;
    if (flush) begin
      hwm_d        = '0;
      ovf_sticky_d = 1'b0;
    end else begin
      if (level_d > hwm_q) begin
        hwm_d = level_d;
      end
      if (s_valid && full) begin
        ovf_sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q        <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      hwm_q        <= hwm_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign hwm        = hwm_q;
  assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_dma_stream_fifo.sv
// Scoreboard bench for dma_stream_fifo: a cut-through and a store-and-forward
// instance (both DEPTH=4, 32-bit data). Honors DMA_STREAM_FIFO_STATS_EN.
module tb_dma_stream_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned KW    = DW / 8;
  localparam int unsigned DEP   = 4;
  localparam int unsigned LW    = $clog2(DEP + 1);
  localparam int unsigned ENT_W = DW + KW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: cut-through, AF=3, AE=1
  logic          flush_a = 1'b0, s_valid_a = 1'b0, s_last_a = 1'b0, m_ready_a = 1'b0;
  logic [DW-1:0] s_data_a = '0;
  logic [KW-1:0] s_keep_a = '0;
  logic          s_ready_a, m_valid_a, m_last_a, full_a, empty_a, af_a, ae_a;
  logic [DW-1:0] m_data_a;
  logic [KW-1:0] m_keep_a;
  logic [LW-1:0] level_a, pkt_a;
`ifdef DMA_STREAM_FIFO_STATS_EN
  logic [LW-1:0] hwm_a;
  logic          ovf_a;
`endif

  // Instance B: store-and-forward, default thresholds
  logic          flush_b = 1'b0, s_valid_b = 1'b0, s_last_b = 1'b0, m_ready_b = 1'b0;
  logic [DW-1:0] s_data_b = '0;
  logic [KW-1:0] s_keep_b = '0;
  logic          s_ready_b, m_valid_b, m_last_b, full_b, empty_b, af_b, ae_b;
  logic [DW-1:0] m_data_b;
  logic [KW-1:0] m_keep_b;
  logic [LW-1:0] level_b, pkt_b;
`ifdef DMA_STREAM_FIFO_STATS_EN
  logic [LW-1:0] hwm_b;
  logic          ovf_b;
`endif

  dma_stream_fifo #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(3), .AE_THRESH(1), .PKT_MODE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a), .s_keep(s_keep_a), .s_last(s_last_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a), .m_keep(m_keep_a), .m_last(m_last_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .level(level_a), .pkt_count(pkt_a)
`ifdef DMA_STREAM_FIFO_STATS_EN
    , .hwm(hwm_a), .ovf_sticky(ovf_a)
`endif
  );

  dma_stream_fifo #(.DATA_W(DW), .DEPTH(DEP), .PKT_MODE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b), .s_keep(s_keep_b), .s_last(s_last_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_keep(m_keep_b), .m_last(m_last_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .level(level_b), .pkt_count(pkt_b)
`ifdef DMA_STREAM_FIFO_STATS_EN
    , .hwm(hwm_b), .ovf_sticky(ovf_b)
`endif
  );

  logic [ENT_W-1:0] qa[$];
  logic [ENT_W-1:0] qb[$];
  logic             pushed_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample handshakes just before the edge, update scoreboards, then step past the edge
  task automatic tick();
    logic [ENT_W-1:0] e;
    #1;
    if (s_valid_a && s_ready_a) qa.push_back({s_last_a, s_keep_a, s_data_a});
    if (m_valid_a && m_ready_a) begin
      check("a_pop_expected", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_beat", 64'({m_last_a, m_keep_a, m_data_a}), 64'(e));
      end
    end
    pushed_b = s_valid_b && s_ready_b;
    if (pushed_b) qb.push_back({s_last_b, s_keep_b, s_data_b});
    if (m_valid_b && m_ready_b) begin
      check("b_pop_expected", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_beat", 64'({m_last_b, m_keep_b, m_data_b}), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_empty", 64'(empty_a), 64'd1);
    check("rst_full", 64'(full_a), 64'd0);
    check("rst_ae", 64'(ae_a), 64'd1);
    check("rst_af", 64'(af_a), 64'd0);
    check("rst_m_valid", 64'(m_valid_a), 64'd0);
    check("rst_s_ready", 64'(s_ready_a), 64'd1);
    check("rst_b_level", 64'(level_b), 64'd0);

    // Test 1: async reset at level 3
    for (int i = 0; i < 3; i++) begin
      s_valid_a = 1'b1; s_data_a = DW'(32'hA0 + i); s_keep_a = 4'hF; s_last_a = 1'b1;
      tick();
    end
    s_valid_a = 1'b0; s_last_a = 1'b0;
    check("t1_pre_level", 64'(level_a), 64'd3);
    check("t1_pre_pkt", 64'(pkt_a), 64'd3);
    rst_n = 1'b0;
    #1;
    check("t1_level", 64'(level_a), 64'd0);
    check("t1_empty", 64'(empty_a), 64'd1);
    check("t1_m_valid", 64'(m_valid_a), 64'd0);
    check("t1_s_ready", 64'(s_ready_a), 64'd1);
    check("t1_pkt", 64'(pkt_a), 64'd0);
    qa.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Test 2: fill to full, overflow attempt held off, drain in order
    m_ready_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      s_valid_a = 1'b1; s_data_a = DW'(32'h11 * k); s_keep_a = KW'(k);
      tick();
      check("t2_level", 64'(level_a), 64'(k));
      check("t2_af", 64'(af_a), 64'(k >= 3));
      check("t2_full", 64'(full_a), 64'(k == 4));
      check("t2_ae", 64'(ae_a), 64'(k <= 1));
    end
    s_data_a = DW'(32'h55);
    #1;
    check("t2_s_ready_full", 64'(s_ready_a), 64'd0);
    tick();
    check("t2_level_hold", 64'(level_a), 64'd4);
`ifdef DMA_STREAM_FIFO_STATS_EN
    check("t2_hwm", 64'(hwm_a), 64'd4);
    check("t2_ovf", 64'(ovf_a), 64'd1);
`endif
    s_valid_a = 1'b0; m_ready_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t2_drain_level", 64'(level_a), 64'(4 - k));
    end
    check("t2_empty", 64'(empty_a), 64'd1);
    check("t2_m_valid", 64'(m_valid_a), 64'd0);

    // Test 3: steady-state push+pop at level 2 across pointer wraps
    m_ready_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid_a = 1'b1; s_data_a = DW'(32'h100 + i); s_keep_a = 4'hF;
      tick();
    end
    m_ready_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data_a = DW'(32'h102 + i); s_keep_a = KW'(i + 1);
      tick();
      check("t3_level", 64'(level_a), 64'd2);
    end
    s_valid_a = 1'b0;
    repeat (2) tick();
    check("t3_empty", 64'(empty_a), 64'd1);

    // Test 6: flush at level 3 while a push is offered
    m_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid_a = 1'b1; s_data_a = DW'(32'h200 + i); s_last_a = (i == 1);
      tick();
    end
    s_last_a = 1'b0;
    flush_a = 1'b1; m_ready_a = 1'b1;
    #1;
    check("t6_s_ready", 64'(s_ready_a), 64'd0);
    check("t6_m_valid", 64'(m_valid_a), 64'd0);
    tick();
    flush_a = 1'b0; s_valid_a = 1'b0; m_ready_a = 1'b0;
    qa.delete();
    check("t6_level", 64'(level_a), 64'd0);
    check("t6_empty", 64'(empty_a), 64'd1);
    check("t6_pkt", 64'(pkt_a), 64'd0);
`ifdef DMA_STREAM_FIFO_STATS_EN
    check("t6_hwm", 64'(hwm_a), 64'd0);
    check("t6_ovf", 64'(ovf_a), 64'd0);
`endif

    // Test 4: store-and-forward holds a 3-beat packet until its last beat
    m_ready_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid_b = 1'b1; s_data_b = DW'(32'h300 + i); s_keep_b = KW'(4'h1 << i); s_last_b = (i == 2);
      #1;
      check("t4_m_valid_hold", 64'(m_valid_b), 64'd0);
      tick();
    end
    s_valid_b = 1'b0; s_last_b = 1'b0;
    check("t4_m_valid", 64'(m_valid_b), 64'd1);
    check("t4_pkt", 64'(pkt_b), 64'd1);
    m_ready_b = 1'b1;
    repeat (3) tick();
    check("t4_pkt_after", 64'(pkt_b), 64'd0);
    check("t4_m_valid_after", 64'(m_valid_b), 64'd0);

    // Test 5: oversize 6-beat packet released by the full condition
    m_ready_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid_b = 1'b1; s_data_b = DW'(32'h400 + i); s_keep_b = KW'(4'hF >> i); s_last_b = 1'b0;
      tick();
    end
    check("t5_full", 64'(full_b), 64'd1);
    check("t5_pkt", 64'(pkt_b), 64'd0);
    check("t5_m_valid", 64'(m_valid_b), 64'd1);
    m_ready_b = 1'b1;
    idx = 4;
    for (int cyc = 0; cyc < 40 && (idx < 6 || qb.size() != 0); cyc++) begin
      s_valid_b = (idx < 6);
      s_data_b  = DW'(32'h400 + idx);
      s_keep_b  = KW'(4'h9 ^ idx);
      s_last_b  = (idx == 5);
      tick();
      if (pushed_b) idx++;
    end
    s_valid_b = 1'b0; s_last_b = 1'b0; m_ready_b = 1'b0;
    check("t5_all_pushed", 64'(idx), 64'd6);
    check("t5_sb_drained", 64'(qb.size()), 64'd0);
    check("t5_empty", 64'(empty_b), 64'd1);
    check("t5_pkt_end", 64'(pkt_b), 64'd0);

    check("a_sb_drained", 64'(qa.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_stream_fifo.md
Name: dma_stream_fifo

Overview:
Parametrised synchronous FIFO for the MM2S datapath, carrying stream beats (data + byte-keep + last) between the AXI read-response side and the stream output. Successor to the basic data FIFO. Adds:
- valid/ready handshakes on both sides
- sideband storage
- programmable almost-full/almost-empty thresholds
- packet (store-and-forward) mode with packet counting
- synchronous flush

Parameters:
DATA_W, 64, data width in bits; multiple of 8
DEPTH, 16, entry count; power of two, >= 2
AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH; 1..DEPTH
AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH; 0..DEPTH-1
PKT_MODE, 0, 0 = cut-through, 1 = store-and-forward

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush, active high
s_valid  in  1  input beat valid
s_ready  out  1  FIFO can accept beat
s_data  in  DATA_W  input data
s_keep  in  DATA_W/8  input byte enables
s_last  in  1  last beat of packet
m_valid  out  1  head beat valid
m_ready  in  1  consumer accepts head beat
m_data  out  DATA_W  head data
m_keep  out  DATA_W/8  head byte enables
m_last  out  1  head last flag
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  $clog2(DEPTH+1)  occupancy
pkt_count  out  $clog2(DEPTH+1)  complete packets (entries with last=1) stored

Behaviour:
- Reset (rst_n low, async) clears rd_ptr, wr_ptr, level and pkt_count to 0. Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0, m_valid=0, s_ready=1.
- Storage is not reset. m_data/m_keep/m_last are meaningful only while m_valid=1.
- Each entry stores {last, keep, data}. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- s_ready = !full && !flush. A push occurs when s_valid && s_ready.
- m_valid depends on mode:
  - PKT_MODE=0: m_valid = !empty && !flush.
  - PKT_MODE=1: m_valid = !empty && !flush && (pkt_count != 0 || full).
  - The full term releases an oversize packet (longer than DEPTH) in cut-through fashion and prevents deadlock.
- A pop occurs when m_valid && m_ready.
- Head output is first-word-fall-through: combinational read of mem[rd_ptr], zero cycles from pointer to output.
- Latency: a beat pushed at edge N is visible with m_valid=1 after edge N (PKT_MODE=0). In PKT_MODE=1 it becomes visible after the edge that pushes its packet's last beat.
- Head stability: while m_valid && !m_ready, m_data/m_keep/m_last stay stable.
- Level update: push only = +1; pop only = -1; push and pop together or neither = unchanged.
- pkt_count update: +1 on a push with s_last=1; -1 on a pop with m_last=1; both together = unchanged.
- Full is not pass-through: with full=1, s_ready=0 even if a pop occurs the same cycle.
- Empty: no push-to-output bypass. A simultaneous push/pop is only possible when level >= 1.
- Flush:
  - The cycle flush=1, push and pop are suppressed (s_ready=0, m_valid=0).
  - On the next edge, pointers, level and pkt_count become 0.
  - A flush arriving mid-packet discards the partial packet.
  - Reset has priority over flush.
- Elaboration $error if any of:
  - DEPTH is not a power of two or is < 2
  - DATA_W%8 != 0
  - a threshold is out of range

Optional Feature:
Macro DMA_STREAM_FIFO_STATS_EN.
- Defined: adds output ports hwm [$clog2(DEPTH+1)] and ovf_sticky [1].
  - hwm: maximum level reached.
  - ovf_sticky: set when s_valid=1 && full=1.
  - Both are cleared by reset or flush; hwm updates from the next-state level.
- Undefined: the ports and logic are absent. Core behaviour is identical.

Decomposition:
- Package dma_fifo_pkg:
  - function is_pow2
  - function lvl_w(depth) returning $clog2(depth+1)
  - localparam KEEP_BITS_PER_BYTE=8
  - typedef enum fifo_mode_e {FIFO_CUT_THROUGH, FIFO_STORE_FWD} used for PKT_MODE
- Sub-module dma_fifo_mem: simple dual-port array (1 write port, 1 async read port), width DATA_W+DATA_W/8+1, no reset.

Test Plan:
1. Reset mid-operation at level 3 → same cycle: level=0, empty=1, m_valid=0, s_ready=1, pkt_count=0.
2. DEPTH=4, AF=3, m_ready=0, push 0x11,0x22,0x33,0x44,0x55 → almost_full after 3rd edge; full=1 and s_ready=0 after 4th; 0x55 held off. Drain yields 0x11..0x44 in order; empty=1 after 4th pop.
3. Level 2, s_valid=m_ready=1 for 10 cycles with incrementing data → level stays 2 throughout, output order exact across 2+ pointer wraps.
4. PKT_MODE=1, push 3 beats with s_last on 3rd → m_valid=0 until after the 3rd push edge, then pkt_count=1. After popping the last beat, pkt_count=0 and m_valid=0.
5. PKT_MODE=1, DEPTH=4, 6-beat packet → m_valid rises when full with pkt_count=0. All 6 beats arrive in order with keep intact; m_last=1 only on the 6th.
6. flush=1 at level 3 with s_valid=1 → s_ready=0 and m_valid=0 that cycle; next cycle level=0, empty=1, pkt_count=0. With STATS_EN: hwm=0, ovf_sticky=0.
